// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: latches a 128-bit state, transforms COLS_PER_CYCLE
// columns per clock and presents the result over a valid/ready handshake.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $fatal(1, "inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Step wraps to 0 for four columns per cycle; the 2-bit counter then never moves.
    localparam logic [1:0] COL_STEP   = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_START = 2'(4 - COLS_PER_CYCLE);

    state_e       state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [127:0] data_q, data_d;
    logic [127:0] out_q, out_d;
    logic [1:0]   col_sel_s;
    logic         in_fire_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                       m9[0] ^ me[1] ^ mb[2] ^ md[3],
                       md[0] ^ m9[1] ^ me[2] ^ mb[3],
                       mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign in_fire_s = in_ready & in_valid;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_q;

    // Next-state, column sequencing and output column writes.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        data_d    = data_q;
        out_d     = out_q;
        col_sel_s = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (in_fire_s) begin
                    data_d    = in_data;
                    col_cnt_d = 2'd0;
                    state_d   = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    col_sel_s = col_cnt_q + k[1:0];
                    out_d[32*(3-int'(col_sel_s)) +: 32] =
                        inv_mix_col(data_q[32*(3-int'(col_sel_s)) +: 32]);
                end
                if (col_cnt_q == LAST_START) begin
                    col_cnt_d = 2'd0;
                    state_d   = S_DONE;
                end else begin
                    col_cnt_d = col_cnt_q + COL_STEP;
                    state_d   = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        data_d    = in_data;
                        col_cnt_d = 2'd0;
                        state_d   = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                col_cnt_d = 2'd0;
            end
        endcase
    end

    // State, counter, latched input and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            col_cnt_q <= 2'd0;
            data_q    <= 128'd0;
            out_q     <= 128'd0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            data_q    <= data_d;
            out_q     <= out_d;
        end
    end

endmodule
